scroll_offset_gen: RTL and testbench

//   Frame-synchronised horizontal scroll controller driving the text scroller's x-offset input.

---
 rtl/scroll_offset_gen.sv | 179 +++++++++++++++++
 tb/tb_scroll_offset_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_offset_gen.sv
// Frame-synchronised horizontal scroll offset generator with debounced pause/speed/direction buttons.
// Optional build macro SINGLE_STEP_EN: while paused, a speed press steps the offset once instead of changing speed.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RUN    | offset advances every (8 >> speed_level) frame starts
// ST_PAUSED | offset and frame counter frozen, frame starts ignored
module scroll_offset_gen #(
  parameter int TEXT_WIDTH_PX   = 192,
  parameter int OFFSET_W        = 9,
  parameter int DEBOUNCE_CYCLES = 62500
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_begin,
  input  logic                btn_pause,
  input  logic                btn_speed,
  input  logic                btn_dir,
  output logic [OFFSET_W-1:0] scroll_offset,
  output logic                offset_valid,
  output logic                wrap_pulse,
  output logic                paused,
  output logic [1:0]          speed_level,
  output logic                dir
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_PAUSED = 1'b1;

  localparam int                  DB_W        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]     DB_LOAD     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [OFFSET_W-1:0] OFFSET_LAST = OFFSET_W'(TEXT_WIDTH_PX - 1);

  logic [2:0] btn_raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] press;

  assign btn_raw = {btn_dir, btn_speed, btn_pause};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Down-counter reloads whenever the synced input matches the accepted level,
  // so the level flips only after DEBOUNCE_CYCLES consecutive differing samples.
  for (genvar i = 0; i < 3; i++) begin : g_db
    logic [DB_W-1:0] db_cnt;
    logic            db_q;
    logic            press_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        db_cnt  <= DB_LOAD;
        db_q    <= 1'b0;
        press_q <= 1'b0;
      end else begin
        press_q <= 1'b0;
        if (sync2[i] == db_q) begin
          db_cnt <= DB_LOAD;
        end else if (db_cnt == '0) begin
          db_q    <= sync2[i];
          db_cnt  <= DB_LOAD;
          press_q <= sync2[i];
        end else begin
          db_cnt <= db_cnt - 1'b1;
        end
      end
    end

    assign press[i] = press_q;
  end

  logic       pause_press;
  logic       speed_press;
  logic       dir_press;
  logic       fb_q;
  logic       frame_tick;
  logic [0:0] state;
  logic [0:0] state_nxt;
  logic [2:0] frame_cnt;
  logic [2:0] frame_cnt_nxt;
  logic [2:0] div_m1;
  logic       frame_due;
  logic       manual_step;
  logic       speed_change;
  logic       do_step;
  logic [OFFSET_W-1:0] offset_nxt;
  logic       wrap_nxt;

  assign pause_press = press[0];
  assign speed_press = press[1];
  assign dir_press   = press[2];

  assign frame_tick = frame_begin & ~fb_q;
  assign div_m1     = 3'd7 >> speed_level;

`ifdef SINGLE_STEP_EN
  assign manual_step  = (state == ST_PAUSED) && speed_press;
  assign speed_change = (state == ST_RUN) && speed_press;
`else
  assign manual_step  = 1'b0;
  assign speed_change = speed_press;
`endif

  // A pause press in the same cycle as a due step suppresses the step.
  assign frame_due = (state == ST_RUN) && frame_tick && !pause_press && (frame_cnt == div_m1);
  assign do_step   = frame_due | manual_step;

  always_comb begin
    state_nxt = state;
    if (pause_press) begin
      state_nxt = (state == ST_RUN) ? ST_PAUSED : ST_RUN;
    end

    frame_cnt_nxt = frame_cnt;
    if ((state == ST_RUN) && frame_tick && !pause_press) begin
      frame_cnt_nxt = (frame_cnt == div_m1) ? 3'd0 : frame_cnt + 3'd1;
    end
    if (speed_change) begin
      frame_cnt_nxt = 3'd0;
    end

    offset_nxt = scroll_offset;
    wrap_nxt   = 1'b0;
    if (do_step) begin
      if (!dir) begin
        if (scroll_offset == OFFSET_LAST) begin
          offset_nxt = '0;
          wrap_nxt   = 1'b1;
        end else begin
          offset_nxt = scroll_offset + 1'b1;
        end
      end else begin
        if (scroll_offset == '0) begin
          offset_nxt = OFFSET_LAST;
          wrap_nxt   = 1'b1;
        end else begin
          offset_nxt = scroll_offset - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fb_q          <= 1'b0;
      state         <= ST_RUN;
      frame_cnt     <= 3'd0;
      scroll_offset <= '0;
      offset_valid  <= 1'b0;
      wrap_pulse    <= 1'b0;
      speed_level   <= 2'd1;
      dir           <= 1'b0;
    end else begin
      fb_q          <= frame_begin;
      state         <= state_nxt;
      frame_cnt     <= frame_cnt_nxt;
      scroll_offset <= offset_nxt;
      offset_valid  <= do_step;
      wrap_pulse    <= wrap_nxt;
      if (speed_change) begin
        speed_level <= speed_level + 2'd1;
      end
      if (dir_press) begin
        dir <= ~dir;
      end
    end
  end

  assign paused = (state == ST_PAUSED);

endmodule

// File: tb/tb_scroll_offset_gen.sv
// Directed bench for scroll_offset_gen: table of press/frame sequences plus hand-written
// sequences for debounce glitches, press/step coincidence and clock-less reset.
module tb_scroll_offset_gen;

  localparam int TW = 192;
  localparam int OW = 9;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          clk_run = 1'b1;
  logic          reset = 1'b0;
  logic          frame_begin = 1'b0;
  logic          btn_pause = 1'b0;
  logic          btn_speed = 1'b0;
  logic          btn_dir = 1'b0;
  logic [OW-1:0] scroll_offset;
  logic          offset_valid;
  logic          wrap_pulse;
  logic          paused;
  logic [1:0]    speed_level;
  logic          dir;

  scroll_offset_gen #(
    .TEXT_WIDTH_PX  (TW),
    .OFFSET_W       (OW),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_begin  (frame_begin),
    .btn_pause    (btn_pause),
    .btn_speed    (btn_speed),
    .btn_dir      (btn_dir),
    .scroll_offset(scroll_offset),
    .offset_valid (offset_valid),
    .wrap_pulse   (wrap_pulse),
    .paused       (paused),
    .speed_level  (speed_level),
    .dir          (dir)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_wrap   = 0;

  always @(negedge clk) begin
    if (offset_valid) n_valid++;
    if (wrap_pulse)   n_wrap++;
  end

  typedef struct {
    bit do_reset;
    int n_speed;
    int n_dir;
    int n_pause;
    int n_frames;
    int exp_offset;
    int exp_speed;
    bit exp_dir;
    bit exp_paused;
    int exp_valid;
    int exp_wrap;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    frame_begin = 1'b0;
    btn_pause = 1'b0;
    btn_speed = 1'b0;
    btn_dir = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic press(input int which);
    @(negedge clk);
    case (which)
      0: btn_pause = 1'b1;
      1: btn_speed = 1'b1;
      default: btn_dir = 1'b1;
    endcase
    repeat (10) @(negedge clk);
    btn_pause = 1'b0;
    btn_speed = 1'b0;
    btn_dir = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      @(negedge clk);
      frame_begin = 1'b1;
      @(negedge clk);
      frame_begin = 1'b0;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, w0;

    //          rst spd dir pau frm  off  spd dir pau val wrap
    vecs[0] = '{1,  0,  0,  0,  0,   0,   1,  0,  0,  0,  0};
    vecs[1] = '{0,  0,  0,  0,  8,   2,   1,  0,  0,  2,  0};
    vecs[2] = '{1,  2,  0,  0,  192, 0,   3,  0,  0,  192, 1};
    vecs[3] = '{1,  0,  1,  0,  4,   191, 1,  1,  0,  1,  1};
    vecs[4] = '{0,  0,  0,  0,  8,   189, 1,  1,  0,  2,  0};
    vecs[5] = '{0,  3,  0,  0,  16,  187, 0,  1,  0,  2,  0};
    vecs[6] = '{0,  0,  0,  1,  10,  187, 0,  1,  1,  0,  0};
    vecs[7] = '{0,  0,  0,  1,  8,   186, 0,  1,  0,  1,  0};
    vecs[8] = '{0,  1,  1,  0,  4,   187, 1,  0,  0,  1,  0};

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].do_reset) do_reset();
      v0 = n_valid;
      w0 = n_wrap;
      repeat (vecs[i].n_speed) press(1);
      repeat (vecs[i].n_dir)   press(2);
      repeat (vecs[i].n_pause) press(0);
      frames(vecs[i].n_frames);
      settle();
      check($sformatf("row%0d offset", i), 32'(scroll_offset), 32'(vecs[i].exp_offset));
      check($sformatf("row%0d speed", i),  32'(speed_level),   32'(vecs[i].exp_speed));
      check($sformatf("row%0d dir", i),    32'(dir),           32'(vecs[i].exp_dir));
      check($sformatf("row%0d paused", i), 32'(paused),        32'(vecs[i].exp_paused));
      check($sformatf("row%0d valid_cnt", i), 32'(n_valid - v0), 32'(vecs[i].exp_valid));
      check($sformatf("row%0d wrap_cnt", i),  32'(n_wrap - w0),  32'(vecs[i].exp_wrap));
    end

    // Short pause glitch must be rejected; a long hold pauses and freezes the offset.
    do_reset();
    @(negedge clk);
    btn_pause = 1'b1;
    repeat (3) @(negedge clk);
    btn_pause = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("glitch paused", 32'(paused), 32'd0);
    press(0);
    #1;
    check("hold paused", 32'(paused), 32'd1);
    v0 = n_valid;
    frames(10);
    settle();
    check("paused offset", 32'(scroll_offset), 32'd0);
    check("paused valid_cnt", 32'(n_valid - v0), 32'd0);

    // Speed press lands on the same edge as the due 4th frame tick at level 1.
    do_reset();
    frames(3);
    v0 = n_valid;
    @(negedge clk);
    btn_speed = 1'b1;
    repeat (6) @(negedge clk);
    frame_begin = 1'b1;
    @(negedge clk);
    #1;
    check("coincide offset", 32'(scroll_offset), 32'd1);
    check("coincide speed", 32'(speed_level), 32'd2);
    check("coincide valid_cnt", 32'(n_valid - v0), 32'd1);
    frame_begin = 1'b0;
    btn_speed = 1'b0;
    repeat (10) @(negedge clk);
    frames(1);
    settle();
    check("coincide 1 frame", 32'(scroll_offset), 32'd1);
    frames(1);
    settle();
    check("coincide 2 frames", 32'(scroll_offset), 32'd2);

    // Reset with the clock stopped must clear everything immediately.
    press(2);
    press(0);
    #1;
    check("pre-reset dir", 32'(dir), 32'd1);
    check("pre-reset paused", 32'(paused), 32'd1);
    @(negedge clk);
    clk_run = 1'b0;
    #23;
    reset = 1'b1;
    #2;
    check("async offset", 32'(scroll_offset), 32'd0);
    check("async valid", 32'(offset_valid), 32'd0);
    check("async wrap", 32'(wrap_pulse), 32'd0);
    check("async paused", 32'(paused), 32'd0);
    check("async speed", 32'(speed_level), 32'd1);
    check("async dir", 32'(dir), 32'd0);
    #10;
    reset = 1'b0;
    clk_run = 1'b1;
    repeat (2) @(negedge clk);

`ifdef SINGLE_STEP_EN
    do_reset();
    press(0);
    v0 = n_valid;
    press(1);
    #1;
    check("single step offset", 32'(scroll_offset), 32'd1);
    check("single step speed", 32'(speed_level), 32'd1);
    check("single step paused", 32'(paused), 32'd1);
    check("single step valid_cnt", 32'(n_valid - v0), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
